// File: rtl/log_dot_accumulator.sv
// rtl/log_dot_accumulator.sv - saturating framed dot-product accumulator for log-multiplier products
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake (in_ready is combinational from state and out_ready)
//   in_product          34-bit approximate product from the log multiplier
//   in_nz1, in_nz2      operand non-zero flags; product is forced to zero unless both are high
//   in_last             final beat of the current frame
//   out_valid/out_ready registered result handshake
//   out_sum             saturated frame sum (ACC_W bits)
//   out_count           beats in the frame, saturating (CNT_W bits)
//   out_zero_beats      beats gated to zero, saturating (CNT_W bits)
//   out_sat             sum saturated at least once in the frame
module log_dot_accumulator #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [33:0]      in_product,
    input  logic             in_nz1,
    input  logic             in_nz2,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_zero_beats,
    output logic             out_sat
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] zero_beats;
    logic             sat_flag;

    logic             accept;
    logic             both_nz;
    logic [33:0]      gated;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_beat;
    logic             sat_beat;
    logic [CNT_W-1:0] count_beat;
    logic [CNT_W-1:0] zero_beats_beat;

    // Downstream consuming the held result frees the slot, so a beat can
    // be taken in the same cycle the result leaves.
    assign in_ready = (state == ACCUM) || out_ready;
    assign accept   = in_valid && in_ready;

    // The multiplier emits a small non-zero approximation for zero operands,
    // so zero operands must be forced to an exact zero here.
    assign both_nz = in_nz1 && in_nz2;
    assign gated   = both_nz ? in_product : 34'd0;

    // One extra bit catches the carry-out that marks saturation.
    assign sum_ext         = {1'b0, acc} + {{(ACC_W-33){1'b0}}, gated};
    assign acc_beat        = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    assign sat_beat        = sat_flag || sum_ext[ACC_W];
    assign count_beat      = (&count) ? count : count + CNT_ONE;
    assign zero_beats_beat = (!both_nz && !(&zero_beats)) ? zero_beats + CNT_ONE : zero_beats;

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept && in_last) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = (accept && in_last) ? HOLD : ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ACCUM;
            acc            <= '0;
            count          <= '0;
            zero_beats     <= '0;
            sat_flag       <= 1'b0;
            out_valid      <= 1'b0;
            out_sum        <= '0;
            out_count      <= '0;
            out_zero_beats <= '0;
            out_sat        <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == HOLD);
            if (accept) begin
                if (in_last) begin
                    out_sum        <= acc_beat;
                    out_count      <= count_beat;
                    out_zero_beats <= zero_beats_beat;
                    out_sat        <= sat_beat;
                    acc            <= '0;
                    count          <= '0;
                    zero_beats     <= '0;
                    sat_flag       <= 1'b0;
                end else begin
                    acc        <= acc_beat;
                    count      <= count_beat;
                    zero_beats <= zero_beats_beat;
                    sat_flag   <= sat_beat;
                end
            end
        end
    end

endmodule

// File: tb/tb_log_dot_accumulator.sv
// tb/tb_log_dot_accumulator.sv - scoreboard bench for log_dot_accumulator (36-bit/8-bit and 48-bit/2-bit instances)
module tb_log_dot_accumulator;

    localparam int AW_W = 36;
    localparam int CW_W = 8;
    localparam int AW_C = 48;
    localparam int CW_C = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [33:0] in_product;
    logic        in_nz1, in_nz2, in_last;
    logic        out_ready;

    logic            in_ready_w, out_valid_w, out_sat_w;
    logic [AW_W-1:0] out_sum_w;
    logic [CW_W-1:0] out_count_w, out_zero_beats_w;

    logic            in_ready_c, out_valid_c, out_sat_c;
    logic [AW_C-1:0] out_sum_c;
    logic [CW_C-1:0] out_count_c, out_zero_beats_c;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;

    typedef struct {
        logic [63:0] sum_w, cnt_w, zb_w;
        bit          sat_w;
        logic [63:0] sum_c, cnt_c, zb_c;
        bit          sat_c;
    } exp_t;

    exp_t exp_q[$];

    logic [63:0] m_acc_w, m_cnt_w, m_zb_w, m_acc_c, m_cnt_c, m_zb_c;
    bit          m_sat_w, m_sat_c;

    always #5 clk = ~clk;

    log_dot_accumulator #(.ACC_W(AW_W), .CNT_W(CW_W)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_product(in_product), .in_nz1(in_nz1), .in_nz2(in_nz2), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w),
        .out_count(out_count_w), .out_zero_beats(out_zero_beats_w), .out_sat(out_sat_w)
    );

    log_dot_accumulator #(.ACC_W(AW_C), .CNT_W(CW_C)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_product(in_product), .in_nz1(in_nz1), .in_nz2(in_nz2), .in_last(in_last),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_sum(out_sum_c),
        .out_count(out_count_c), .out_zero_beats(out_zero_beats_c), .out_sat(out_sat_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Reference accumulation for one configuration.
    task automatic model_step(input int aw, input int cw, input logic [63:0] g, input bit zero,
                              inout logic [63:0] acc, inout logic [63:0] cnt,
                              inout logic [63:0] zb, inout bit sat);
        logic [63:0] amax, cmax, nxt;
        amax = (64'd1 << aw) - 64'd1;
        cmax = (64'd1 << cw) - 64'd1;
        nxt  = acc + g;
        if (nxt > amax) begin
            acc = amax;
            sat = 1'b1;
        end else begin
            acc = nxt;
        end
        if (cnt < cmax) cnt = cnt + 64'd1;
        if (zero && zb < cmax) zb = zb + 64'd1;
    endtask

    // Sampled on the falling edge, so every handshake seen here completes
    // on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            m_acc_w = 0; m_cnt_w = 0; m_zb_w = 0; m_sat_w = 0;
            m_acc_c = 0; m_cnt_c = 0; m_zb_c = 0; m_sat_c = 0;
            exp_q.delete();
        end else begin
            if (out_valid_w && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_pop++;
                    chk("sum_w",   64'(out_sum_w),        e.sum_w);
                    chk("cnt_w",   64'(out_count_w),      e.cnt_w);
                    chk("zb_w",    64'(out_zero_beats_w), e.zb_w);
                    chk("sat_w",   64'(out_sat_w),        64'(e.sat_w));
                    chk("valid_c", 64'(out_valid_c),      64'd1);
                    chk("sum_c",   64'(out_sum_c),        e.sum_c);
                    chk("cnt_c",   64'(out_count_c),      e.cnt_c);
                    chk("zb_c",    64'(out_zero_beats_c), e.zb_c);
                    chk("sat_c",   64'(out_sat_c),        64'(e.sat_c));
                end
            end
            if (in_valid && in_ready_w) begin
                logic [63:0] g;
                bit z;
                z = !(in_nz1 && in_nz2);
                g = z ? 64'd0 : 64'(in_product);
                model_step(AW_W, CW_W, g, z, m_acc_w, m_cnt_w, m_zb_w, m_sat_w);
                model_step(AW_C, CW_C, g, z, m_acc_c, m_cnt_c, m_zb_c, m_sat_c);
                if (in_last) begin
                    exp_t e;
                    e.sum_w = m_acc_w; e.cnt_w = m_cnt_w; e.zb_w = m_zb_w; e.sat_w = m_sat_w;
                    e.sum_c = m_acc_c; e.cnt_c = m_cnt_c; e.zb_c = m_zb_c; e.sat_c = m_sat_c;
                    exp_q.push_back(e);
                    m_acc_w = 0; m_cnt_w = 0; m_zb_w = 0; m_sat_w = 0;
                    m_acc_c = 0; m_cnt_c = 0; m_zb_c = 0; m_sat_c = 0;
                end
            end
        end
    end

    task automatic beat(input logic [33:0] p, input logic n1, input logic n2, input logic l);
        in_product = p;
        in_nz1     = n1;
        in_nz2     = n2;
        in_last    = l;
        in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready_w) break;
        end
        chk("beat_accepted", 64'(in_ready_w), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        in_nz1     = 1'b0;
        in_nz2     = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid_w), 64'd0);
        chk("rst_sum",   64'(out_sum_w),   64'd0);
        chk("rst_ready", 64'(in_ready_w),  64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame
        beat(34'd100, 1, 1, 0);
        beat(34'd200, 1, 1, 0);
        beat(34'd300, 1, 1, 1);
        chk("basic_valid", 64'(out_valid_w), 64'd1);
        chk("basic_sum",   64'(out_sum_w),   64'd600);
        chk("basic_cnt",   64'(out_count_w), 64'd3);
        chk("basic_sat",   64'(out_sat_w),   64'd0);

        // Zero gating
        beat(34'd1, 0, 1, 0);
        beat(34'd1, 1, 0, 0);
        beat(34'd50, 1, 1, 1);
        chk("gate_sum", 64'(out_sum_w),        64'd50);
        chk("gate_zb",  64'(out_zero_beats_w), 64'd2);

        // Saturation on the 36-bit instance, then a clean single-beat frame
        for (int i = 0; i < 5; i++) beat(34'h3_FFFF_FFFF, 1, 1, (i == 4));
        chk("sat_sum", 64'(out_sum_w),   (64'd1 << 36) - 64'd1);
        chk("sat_flag", 64'(out_sat_w),  64'd1);
        chk("sat_cnt", 64'(out_count_w), 64'd5);
        beat(34'd7, 1, 1, 1);
        chk("post_sat_sum",  64'(out_sum_w), 64'd7);
        chk("post_sat_flag", 64'(out_sat_w), 64'd0);

        // Backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        beat(34'd3, 1, 1, 0);
        beat(34'd4, 1, 1, 1);
        in_product = 34'd9; in_nz1 = 1'b1; in_nz2 = 1'b1; in_last = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready_w", 64'(in_ready_w),  64'd0);
            chk("bp_ready_c", 64'(in_ready_c),  64'd0);
            chk("bp_valid",   64'(out_valid_w), 64'd1);
            chk("bp_sum",     64'(out_sum_w),   64'd7);
            chk("bp_cnt",     64'(out_count_w), 64'd2);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("overlap_valid", 64'(out_valid_w), 64'd1);
        chk("overlap_sum",   64'(out_sum_w),   64'd9);

        // Reset mid-frame
        beat(34'd10, 1, 1, 0);
        beat(34'd20, 1, 1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid_w),      64'd0);
        chk("mid_rst_sum",   64'(out_sum_w),        64'd0);
        chk("mid_rst_cnt",   64'(out_count_w),      64'd0);
        chk("mid_rst_zb",    64'(out_zero_beats_w), 64'd0);
        chk("mid_rst_sat",   64'(out_sat_w),        64'd0);
        chk("mid_rst_rdy_c", 64'(in_ready_c),       64'd1);
        beat(34'd5, 1, 1, 1);
        chk("after_rst_sum", 64'(out_sum_w),   64'd5);
        chk("after_rst_cnt", 64'(out_count_w), 64'd1);

        // Count saturation on the 2-bit counter instance
        for (int i = 0; i < 6; i++) beat(34'd1, 1, 1, (i == 5));
        chk("cntsat_cnt_c", 64'(out_count_c), 64'd3);
        chk("cntsat_sum_c", 64'(out_sum_c),   64'd6);
        chk("cntsat_cnt_w", 64'(out_count_w), 64'd6);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty",  64'(exp_q.size()), 64'd0);
        chk("frames_seen",  64'(n_pop),        64'd8);
        chk("idle_valid",   64'(out_valid_w),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
